alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

- Issue stage directly upstream of the combinational ALU.
- Accepts encoded instructions over a valid/ready handshake and reads operands from an internal 8 x 11-bit register file.
- Drives the ALU's `a`, `b` and `sel` inputs, captures its 32-bit result and zero flag, writes the truncated result back and presents a registered response downstream.
- Forms the datapath sequencer around the ALU.

## Interface
- `NREG`, 8: register file depth; r0 reads as 0 and ignores writes.
- `W`, 11: register / operand width; matches the ALU operand width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inValid` input 1: instruction present.
- `inReady` output 1: stage can accept an instruction.
- `instr` input 25: `[24:22]` op, `[21:19]` rd, `[18:16]` rs1, `[15:13]` rs2, `[12]` reserved, `[11]` useImm, `[10:0]` imm.
- `aluA` output 11: ALU operand a.
- `aluB` output 11: ALU operand b.
- `aluSel` output 3: ALU op select.
- `aluRes` input 32: ALU result (combinational).
- `aluZero` input 1: ALU zero flag.
- `resValid` output 1: response valid.
- `resReady` input 1: downstream accepts the response.
- `resData` output 32: full 32-bit result.
- `resRd` output 3: destination register.
- `resZero` output 1: resData == 0.
- `resOvf` output 1: result did not fit in 11 bits.
- `resDivErr` output 1: divide by zero.
- `dbgAddr` input 3: debug read address.
- `dbgData` output 11: combinational read of `rf[dbgAddr]`; r0 reads 0.

## Operation
- **Opcodes:**
  - 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 nand: passed unchanged to `aluSel`.
  - 111 LDI: rd <= imm; ALU is not used and `resData` = zero-extended imm.
- **State machine:**
  - IDLE: `inReady`=1. On `inValid`, latch `instr` into IR and go to READ.
  - READ: opA <= rf[rs1]; opB <= useImm ? imm : rf[rs2]. Go to EXEC.
  - EXEC: drive `aluA`=opA, `aluB`=opB, `aluSel`=op. Capture `aluRes` and `aluZero` into the response registers, write back, go to RESP.
  - RESP: `resValid`=1. On `resReady`, go to IDLE.
- **ALU output idling:** `aluA`, `aluB` and `aluSel` hold opA, opB and op in every state; they are only meaningful in EXEC.
- **Writeback:** in the EXEC cycle, rf[rd] <= aluRes[10:0]; suppressed when rd==0 or on divide error.
- **LDI:** EXEC writes imm; `resZero` = (imm==0).
- **resOvf:**
  - ops 000/001/010: `resOvf` = |aluRes[31:11]|. A negative sub (borrow into upper bits) sets `resOvf`.
  - all other ops: `resOvf`=0.
- **Divide by zero:** op 011 with opB==0:
  - `resData`=0, `resZero`=1, `resDivErr`=1.
  - No writeback; `aluRes` is ignored.
- **Hazards:** none. One instruction is in flight at a time, so the READ of the next instruction sees the completed write.
- **Backpressure:** while RESP waits on `resReady`, all `res*` outputs hold stable and `inReady`=0.

## Timing
- **Accept cycle:** instruction accepted on the edge where `inValid` and `inReady` are both high (call it edge 0).
- **Latency:** READ after edge 0, EXEC after edge 1, RESP (`resValid`=1) after edge 2.
- **Response transfer:** on the edge where `resValid` and `resReady` are both high. `inReady` returns to 1 after that edge.
- **Throughput:** at most one instruction per 4 cycles.
- **Write visibility:** the register write lands on the EXEC->RESP edge. `dbgData` reflects it from RESP onward.
- **Reset (`rst_n`=0), asynchronous, any state including mid-EXEC:**
  - state=IDLE.
  - All rf entries, IR, opA and opB cleared.
  - `inReady`=0 while `rst_n` is low, 1 after release.
  - `resValid`=0; `resData`=0; `resRd`=0; `resZero`, `resOvf`, `resDivErr`=0.
  - `aluA`, `aluB`, `aluSel` = 0.
  - Any in-flight writeback is lost.
- **Reserved bit:** `instr[12]` is ignored.

## Test plan
- **Load and add:** LDI r1=5, LDI r2=3, ADD r3=r1,r2 -> `resData`=8, `resRd`=3, `resZero`=0, `resOvf`=0; `dbgData`(r3)=8; `resValid` rises exactly 3 cycles after each accept.
- **Sub underflow:** with r1=5, r2=3, SUB r4=r2,r1 -> `resData`=0xFFFFFFFE, `resOvf`=1, r4=0x7FE. MUL r5=r1 by imm 0x7FF -> `resData`=10235, `resOvf`=1, r5=10235 & 0x7FF=0x7FB.
- **Divide by zero:** DIV r6=r1 by imm 0 -> `resDivErr`=1, `resData`=0, `resZero`=1, r6 unchanged. DIV by imm 2 -> 2.
- **Backpressure:** hold `resReady`=0 for 5 cycles in RESP -> `res*` outputs stable, `inReady`=0, and a pending `inValid` is not accepted until 1 cycle after the `resReady` handshake.
- **r0 write and NAND:** LDI r0=7 -> `resData`=7, but `dbgData`(r0)=0. NAND r7=r1,r2 with r1=5, r2=3 -> `resOvf`=0, r7=0x7FE.
- **Reset mid-operation:** assert `rst_n` low during EXEC -> immediately `resValid`=0 and all rf reads 0. After release, `inReady`=1 and the next ADD of r1,r2 returns 0 with `resZero`=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue stage in front of a combinational ALU.
// Accepts one encoded instruction at a time and reads its operands from an
// 8 x 11-bit register file (r0 reads as zero). It drives the ALU, captures
// the ALU result, writes the result back and holds a registered response
// until the downstream side accepts it.
// Instruction layout: [24:22] op, [21:19] rd, [18:16] rs1, [15:13] rs2,
// [12] reserved (ignored), [11] useImm, [10:0] imm.
module alu_operand_stage #(
   parameter int NREG = 8,
   parameter int W    = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inValid,
   output logic          inReady,
   input  logic [24:0]   instr,
   output logic [W-1:0]  aluA,
   output logic [W-1:0]  aluB,
   output logic [2:0]    aluSel,
   input  logic [31:0]   aluRes,
   input  logic          aluZero,
   output logic          resValid,
   input  logic          resReady,
   output logic [31:0]   resData,
   output logic [2:0]    resRd,
   output logic          resZero,
   output logic          resOvf,
   output logic          resDivErr,
   input  logic [2:0]    dbgAddr,
   output logic [W-1:0]  dbgData
);

   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_LDI = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t          state_q;
   logic [24:0]     ir_q;
   logic [W-1:0]    opa_q;
   logic [W-1:0]    opb_q;
   logic [W-1:0]    rf_q [NREG];

   logic            res_valid_q;
   logic [31:0]     res_data_q;
   logic [2:0]      res_rd_q;
   logic            res_zero_q;
   logic            res_ovf_q;
   logic            res_div_err_q;

   // Decoded fields of the latched instruction.
   logic [2:0]      ir_op;
   logic [2:0]      ir_rd;
   logic [2:0]      ir_rs1;
   logic [2:0]      ir_rs2;
   logic            ir_use_imm;
   logic [W-1:0]    ir_imm;
   logic            unused_reserved;

   assign ir_op           = ir_q[24:22];
   assign ir_rd           = ir_q[21:19];
   assign ir_rs1          = ir_q[18:16];
   assign ir_rs2          = ir_q[15:13];
   assign unused_reserved = ir_q[12];
   assign ir_use_imm      = ir_q[11];
   assign ir_imm          = ir_q[W-1:0];

   // Next-state values for the response registers and writeback, used in EXEC.
   logic            is_ldi;
   logic            div_err;
   logic            wr_en;
   logic [W-1:0]    wr_data_d;
   logic [31:0]     res_data_d;
   logic            res_zero_d;
   logic            res_ovf_d;

   // Work out what EXEC will capture and whether it writes the register file.
   always_comb begin
      is_ldi     = (ir_op == OP_LDI);
      div_err    = (ir_op == OP_DIV) && (opb_q == '0);
      wr_en      = (state_q == S_EXEC) && (ir_rd != 3'd0) && !div_err;
      wr_data_d  = is_ldi ? ir_imm : aluRes[W-1:0];
      res_data_d = aluRes;
      res_zero_d = aluZero;
      // Only add/sub/mul can spill past the register width; a borrowing
      // subtract lands in the upper bits and therefore also flags here.
      res_ovf_d  = (ir_op <= 3'b010) && (|aluRes[31:W]);
      if (is_ldi) begin
         res_data_d = {{(32-W){1'b0}}, ir_imm};
         res_zero_d = (ir_imm == '0);
      end else if (div_err) begin
         res_data_d = '0;
         res_zero_d = 1'b1;
      end
   end

   // Sequencer: IDLE -> READ -> EXEC -> RESP, with register file and response state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ir_q          <= '0;
         opa_q         <= '0;
         opb_q         <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_rd_q      <= '0;
         res_zero_q    <= 1'b0;
         res_ovf_q     <= 1'b0;
         res_div_err_q <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (inValid) begin
                  ir_q    <= instr;
                  state_q <= S_READ;
               end
            end
            S_READ: begin
               opa_q   <= rf_q[ir_rs1];
               opb_q   <= ir_use_imm ? ir_imm : rf_q[ir_rs2];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               res_valid_q   <= 1'b1;
               res_data_q    <= res_data_d;
               res_rd_q      <= ir_rd;
               res_zero_q    <= res_zero_d;
               res_ovf_q     <= res_ovf_d;
               res_div_err_q <= div_err;
               if (wr_en) begin
                  rf_q[ir_rd] <= wr_data_d;
               end
               state_q <= S_RESP;
            end
            S_RESP: begin
               // Response registers hold untouched until the handshake.
               if (resReady) begin
                  res_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Operand registers feed the ALU in every state; they matter only in EXEC.
   assign aluA      = opa_q;
   assign aluB      = opb_q;
   assign aluSel    = ir_op;

   // Ready is forced low while reset is held, even though state is already IDLE.
   assign inReady   = rst_n && (state_q == S_IDLE);

   assign resValid  = res_valid_q;
   assign resData   = res_data_q;
   assign resRd     = res_rd_q;
   assign resZero   = res_zero_q;
   assign resOvf    = res_ovf_q;
   assign resDivErr = res_div_err_q;

   // r0 is never written, but mask it explicitly so the debug port cannot show it.
   assign dbgData   = (dbgAddr == 3'd0) ? '0 : rf_q[dbgAddr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: provides a behavioural ALU, drives
// randomized and directed instructions, and compares every response and
// register-file readback against a reference model kept in the bench.
module tb_alu_operand_stage;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inValid;
   logic          inReady;
   logic [24:0]   instr;
   logic [10:0]   aluA;
   logic [10:0]   aluB;
   logic [2:0]    aluSel;
   logic [31:0]   aluRes;
   logic          aluZero;
   logic          resValid;
   logic          resReady;
   logic [31:0]   resData;
   logic [2:0]    resRd;
   logic          resZero;
   logic          resOvf;
   logic          resDivErr;
   logic [2:0]    dbgAddr;
   logic [10:0]   dbgData;

   int errors = 0;
   int checks = 0;

   // Reference register file.
   logic [10:0] mrf [8];

   alu_operand_stage #(.NREG(8), .W(11)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inValid   (inValid),
      .inReady   (inReady),
      .instr     (instr),
      .aluA      (aluA),
      .aluB      (aluB),
      .aluSel    (aluSel),
      .aluRes    (aluRes),
      .aluZero   (aluZero),
      .resValid  (resValid),
      .resReady  (resReady),
      .resData   (resData),
      .resRd     (resRd),
      .resZero   (resZero),
      .resOvf    (resOvf),
      .resDivErr (resDivErr),
      .dbgAddr   (dbgAddr),
      .dbgData   (dbgData)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural ALU on zero-extended operands.
   function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [10:0] a, input logic [10:0] b);
      logic [31:0] ea;
      logic [31:0] eb;
      ea = {21'd0, a};
      eb = {21'd0, b};
      case (s)
         3'd0: return ea + eb;
         3'd1: return ea - eb;
         3'd2: return ea * eb;
         3'd3: return (eb == 0) ? 32'h0000_0BAD : ea / eb;
         3'd4: return ea & eb;
         3'd5: return ea | eb;
         3'd6: return ~(ea & eb);
         default: return 32'h1234_5678;
      endcase
   endfunction

   always_comb begin
      aluRes  = alu_f(aluSel, aluA, aluB);
      aluZero = (aluRes == 32'd0);
   end

   function automatic logic [24:0] enc(int op, int rd, int rs1, int rs2, int u, int imm);
      return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], 1'b0, u[0], imm[10:0]};
   endfunction

   // Reference model: expected response of one instruction; updates mrf.
   task automatic model_exec(input logic [24:0] ins, output logic [31:0] d,
                             output logic z, output logic o, output logic e);
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [10:0] a;
      logic [10:0] b;
      logic [10:0] imm;
      op  = ins[24:22];
      rd  = ins[21:19];
      imm = ins[10:0];
      a   = mrf[ins[18:16]];
      b   = ins[11] ? imm : mrf[ins[15:13]];
      o   = 1'b0;
      e   = 1'b0;
      if (op == 3'd7) begin
         d = {21'd0, imm};
         if (rd != 0) mrf[rd] = imm;
      end else if (op == 3'd3 && b == 0) begin
         d = 32'd0;
         e = 1'b1;
      end else begin
         d = alu_f(op, a, b);
         o = (op <= 3'd2) && (d > 32'h7FF);
         if (rd != 0) mrf[rd] = d[10:0];
      end
      z = (d == 32'd0);
   endtask

   // Present an instruction at a negedge; return cycles from accept to resValid.
   task automatic send(input logic [24:0] ins, output int lat);
      inValid = 1'b1;
      instr   = ins;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!resValid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_resp();
      resReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resReady = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inValid = 1'b0; resReady = 1'b0; instr = '0; dbgAddr = '0;
      for (int r = 0; r < 8; r++) mrf[r] = '0;
      #12;
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inReady: got %b want 0", inReady); end
      checks++; if (resValid !== 1'b0) begin errors++; $display("FAIL reset_resValid: got %b want 0", resValid); end
      checks++; if ({aluA, aluB, aluSel} !== 25'd0) begin errors++; $display("FAIL reset_alu: a=%h b=%h sel=%h want 0", aluA, aluB, aluSel); end
      checks++; if ({resData, resRd, resZero, resOvf, resDivErr} !== 38'd0) begin errors++; $display("FAIL reset_res: data=%h rd=%0d z%b o%b e%b want 0", resData, resRd, resZero, resOvf, resDivErr); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_release_inReady: got %b want 1", inReady); end
      @(negedge clk);
   endtask

   task automatic test_load_add();
      logic [24:0] prog [3];
      logic [31:0] ed; logic ez, eo, ee; int lat;
      prog = '{enc(7, 1, 0, 0, 0, 5), enc(7, 2, 0, 0, 0, 3), enc(0, 3, 1, 2, 0, 0)};
      for (int i = 0; i < 3; i++) begin
         model_exec(prog[i], ed, ez, eo, ee);
         send(prog[i], lat);
         checks++; if (lat !== 3) begin errors++; $display("FAIL load_add_latency[%0d]: got %0d want 3", i, lat); end
         checks++; if (resData !== ed || resRd !== prog[i][21:19]) begin errors++; $display("FAIL load_add_data[%0d]: got %h rd%0d want %h rd%0d", i, resData, resRd, ed, prog[i][21:19]); end
         checks++; if ({resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL load_add_flags[%0d]: got zoe=%b%b%b want %b%b%b", i, resZero, resOvf, resDivErr, ez, eo, ee); end
         dbgAddr = prog[i][21:19]; #1;
         checks++; if (dbgData !== mrf[dbgAddr]) begin errors++; $display("FAIL load_add_dbg[%0d]: got %h want %h", i, dbgData, mrf[dbgAddr]); end
         finish_resp();
      end
      dbgAddr = 3'd3; #1;
      checks++; if (dbgData !== 11'd8) begin errors++; $display("FAIL load_add_r3: got %h want 008", dbgData); end
   endtask

   task automatic test_sub_mul();
      logic [24:0] prog [2];
      logic [31:0] ed; logic ez, eo, ee; int lat;
      prog = '{enc(1, 4, 2, 1, 0, 0), enc(2, 5, 1, 0, 1, 11'h7FF)};
      for (int i = 0; i < 2; i++) begin
         model_exec(prog[i], ed, ez, eo, ee);
         send(prog[i], lat);
         checks++; if (lat !== 3 || resData !== ed) begin errors++; $display("FAIL sub_mul_data[%0d]: got %h lat %0d want %h lat 3", i, resData, lat, ed); end
         checks++; if ({resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL sub_mul_flags[%0d]: got zoe=%b%b%b want %b%b%b", i, resZero, resOvf, resDivErr, ez, eo, ee); end
         dbgAddr = prog[i][21:19]; #1;
         checks++; if (dbgData !== mrf[dbgAddr]) begin errors++; $display("FAIL sub_mul_dbg[%0d]: got %h want %h", i, dbgData, mrf[dbgAddr]); end
         finish_resp();
      end
   endtask

   task automatic test_div_zero();
      logic [24:0] prog [2];
      logic [31:0] ed; logic ez, eo, ee; int lat;
      // The first one also sets the reserved bit, which must be ignored.
      prog = '{enc(3, 6, 1, 0, 1, 0) | 25'h0001000, enc(3, 6, 1, 0, 1, 2)};
      for (int i = 0; i < 2; i++) begin
         model_exec(prog[i], ed, ez, eo, ee);
         send(prog[i], lat);
         checks++; if (lat !== 3 || resData !== ed) begin errors++; $display("FAIL div_data[%0d]: got %h lat %0d want %h lat 3", i, resData, lat, ed); end
         checks++; if ({resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL div_flags[%0d]: got zoe=%b%b%b want %b%b%b", i, resZero, resOvf, resDivErr, ez, eo, ee); end
         dbgAddr = 3'd6; #1;
         checks++; if (dbgData !== mrf[6]) begin errors++; $display("FAIL div_r6[%0d]: got %h want %h", i, dbgData, mrf[6]); end
         finish_resp();
      end
   endtask

   task automatic test_backpressure();
      logic [24:0] a; logic [24:0] b;
      logic [31:0] ed; logic ez, eo, ee; int lat;
      a = enc(0, 3, 1, 2, 0, 0);
      b = enc(1, 4, 3, 1, 0, 0);
      model_exec(a, ed, ez, eo, ee);
      send(a, lat);
      checks++; if (lat !== 3 || resData !== ed) begin errors++; $display("FAIL bp_first: got %h lat %0d want %h lat 3", resData, lat, ed); end
      // A second instruction waits on the input while the response is held.
      inValid = 1'b1;
      instr   = b;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (resValid !== 1'b1 || inReady !== 1'b0 || resData !== ed || resRd !== 3'd3 ||
             {resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h rd=%0d want valid=1 ready=0 data=%h rd=3", k, resValid, inReady, resData, resRd, ed);
         end
      end
      finish_resp();
      checks++; if (inReady !== 1'b1 || resValid !== 1'b0) begin errors++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", inReady, resValid); end
      model_exec(b, ed, ez, eo, ee);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!resValid && lat < 20) begin @(negedge clk); lat++; end
      checks++; if (lat !== 3 || resData !== ed || resRd !== 3'd4) begin errors++; $display("FAIL bp_pending: got %h rd%0d lat %0d want %h rd4 lat 3", resData, resRd, lat, ed); end
      finish_resp();
   endtask

   task automatic test_r0_nand();
      logic [24:0] prog [2];
      logic [31:0] ed; logic ez, eo, ee; int lat;
      prog = '{enc(7, 0, 0, 0, 0, 7), enc(6, 7, 1, 2, 0, 0)};
      for (int i = 0; i < 2; i++) begin
         model_exec(prog[i], ed, ez, eo, ee);
         send(prog[i], lat);
         checks++; if (lat !== 3 || resData !== ed || resRd !== prog[i][21:19]) begin errors++; $display("FAIL r0_nand_data[%0d]: got %h rd%0d lat %0d want %h", i, resData, resRd, lat, ed); end
         checks++; if ({resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL r0_nand_flags[%0d]: got zoe=%b%b%b want %b%b%b", i, resZero, resOvf, resDivErr, ez, eo, ee); end
         dbgAddr = prog[i][21:19]; #1;
         checks++; if (dbgData !== mrf[dbgAddr]) begin errors++; $display("FAIL r0_nand_dbg[%0d]: got %h want %h", i, dbgData, mrf[dbgAddr]); end
         finish_resp();
      end
   endtask

   task automatic test_random();
      logic [24:0] ins;
      logic [31:0] ed; logic ez, eo, ee; int lat; int imm;
      for (int i = 0; i < 40; i++) begin
         imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : int'($urandom_range(0, 2047));
         ins = enc(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), imm);
         ins[12] = 1'($urandom_range(0, 1));
         model_exec(ins, ed, ez, eo, ee);
         send(ins, lat);
         checks++; if (lat !== 3 || resData !== ed || resRd !== ins[21:19]) begin errors++; $display("FAIL rand_data[%0d]: ins=%h got %h rd%0d lat %0d want %h", i, ins, resData, resRd, lat, ed); end
         checks++; if ({resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL rand_flags[%0d]: ins=%h got zoe=%b%b%b want %b%b%b", i, ins, resZero, resOvf, resDivErr, ez, eo, ee); end
         dbgAddr = 3'($urandom_range(0, 7)); #1;
         checks++; if (dbgData !== mrf[dbgAddr]) begin errors++; $display("FAIL rand_dbg[%0d]: r%0d got %h want %h", i, dbgAddr, dbgData, mrf[dbgAddr]); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         finish_resp();
      end
   endtask

   task automatic test_reset_mid();
      logic [24:0] a;
      logic [31:0] ed; logic ez, eo, ee; int lat;
      a = enc(0, 3, 1, 2, 0, 0);
      inValid = 1'b1;
      instr   = a;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      // The stage is in EXEC now; reset before its writeback edge.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (resValid !== 1'b0 || inReady !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: valid=%b ready=%b want 0 0", resValid, inReady); end
      checks++; if ({aluA, aluB, aluSel, resData} !== 57'd0) begin errors++; $display("FAIL rmid_regs: a=%h b=%h sel=%h data=%h want 0", aluA, aluB, aluSel, resData); end
      for (int r = 0; r < 8; r++) begin
         mrf[r] = '0;
         dbgAddr = 3'(r); #1;
         checks++; if (dbgData !== 11'd0) begin errors++; $display("FAIL rmid_rf[%0d]: got %h want 000", r, dbgData); end
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rmid_release: ready=%b want 1", inReady); end
      @(negedge clk);
      model_exec(a, ed, ez, eo, ee);
      send(a, lat);
      checks++; if (lat !== 3 || resData !== 32'd0 || resZero !== 1'b1) begin errors++; $display("FAIL rmid_add: got %h z%b lat %0d want 0 z1 lat 3", resData, resZero, lat); end
      checks++; if (resData !== ed || {resZero, resOvf, resDivErr} !== {ez, eo, ee}) begin errors++; $display("FAIL rmid_model: got %h zoe=%b%b%b want %h %b%b%b", resData, resZero, resOvf, resDivErr, ed, ez, eo, ee); end
      finish_resp();
   endtask

   initial begin
      test_reset();
      test_load_add();
      test_sub_mul();
      test_div_zero();
      test_backpressure();
      test_r0_nand();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
